wave_fetch: RTL

WAVE_FETCH -- requirements
Module: wave_fetch

---
 rtl/wave_fetch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/wave_fetch.sv
// wave_fetch: copies one WAVE_LEN-sample waveform per frame from a wave RAM into a column buffer and tracks its peaks.
// Define WAVE_FETCH_DBUF_EN for a double-buffered column store that swaps banks when a fetch completes.
module wave_fetch #(
    parameter int WAVE_LEN = 300,
    parameter int RD_LAT   = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       frame_start,
    output logic       ram_rd_clk,
    output logic       ram_rd_en,
    output logic [8:0] wave_rd_addr,
    input  logic [7:0] wave_rd_data,
    output logic       ram_rd_over,
    output logic       busy,
    output logic       buf_valid,
    input  logic [8:0] col_addr,
    output logic [7:0] col_data,
    output logic [7:0] wave_max,
    output logic [7:0] wave_min
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [8:0] LAST_ADDR  = 9'(WAVE_LEN - 1);
    localparam logic [1:0] LAST_DRAIN = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              ram_rd_en_q, ram_rd_en_d;
    logic [8:0]        rd_addr_q, rd_addr_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic              over_q, over_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [RD_LAT-1:0] dly_en_q, dly_en_d;
    logic [8:0]        dly_addr_q [RD_LAT];
    logic [8:0]        dly_addr_d [RD_LAT];
    logic              first_q, first_d;
    logic [7:0]        run_max_q, run_max_d;
    logic [7:0]        run_min_q, run_min_d;
    logic [7:0]        max_q, max_d;
    logic [7:0]        min_q, min_d;
    logic [7:0]        col_q, col_d;
    logic              cap_en;
    logic [8:0]        cap_addr;
    logic [7:0]        rd_sample;

    always_comb begin
        state_d     = state_q;
        ram_rd_en_d = 1'b0;
        rd_addr_d   = '0;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = READ;
                    ram_rd_en_d = 1'b1;
                end
            end
            READ: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    ram_rd_en_d = 1'b1;
                    rd_addr_d   = rd_addr_q + 9'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        over_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
        valid_d = valid_q | (state_d == DONE);
    end

    // Read requests travel through an RD_LAT-deep pipe so each capture lines up with its returning data.
    always_comb begin
        dly_en_d[0]   = ram_rd_en_q;
        dly_addr_d[0] = rd_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            dly_en_d[i]   = dly_en_q[i-1];
            dly_addr_d[i] = dly_addr_q[i-1];
        end
    end

    assign cap_en   = dly_en_q[RD_LAT-1];
    assign cap_addr = dly_addr_q[RD_LAT-1];

    always_comb begin
        first_d   = first_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        if (cap_en) begin
            first_d = 1'b0;
            if (first_q || wave_rd_data > run_max_q) run_max_d = wave_rd_data;
            if (first_q || wave_rd_data < run_min_q) run_min_d = wave_rd_data;
        end
        if (state_q == IDLE && frame_start) first_d = 1'b1;
        max_d = (state_q == DONE) ? run_max_q : max_q;
        min_d = (state_q == DONE) ? run_min_q : min_q;
        col_d = ({1'b0, col_addr} < 10'(WAVE_LEN)) ? rd_sample : 8'd0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ram_rd_en_q <= 1'b0;
            rd_addr_q   <= '0;
            drain_cnt_q <= '0;
            over_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            dly_en_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) dly_addr_q[i] <= '0;
            first_q     <= 1'b0;
            run_max_q   <= '0;
            run_min_q   <= '0;
            max_q       <= '0;
            min_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            ram_rd_en_q <= ram_rd_en_d;
            rd_addr_q   <= rd_addr_d;
            drain_cnt_q <= drain_cnt_d;
            over_q      <= over_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            dly_en_q    <= dly_en_d;
            dly_addr_q  <= dly_addr_d;
            first_q     <= first_d;
            run_max_q   <= run_max_d;
            run_min_q   <= run_min_d;
            max_q       <= max_d;
            min_q       <= min_d;
            col_q       <= col_d;
        end
    end

`ifdef WAVE_FETCH_DBUF_EN
    // Captures fill the back bank; the display only ever sees the front bank.
    logic [7:0] mem_q [2][WAVE_LEN];
    logic       front_q, front_d;

    always_comb front_d = (state_q == DONE) ? ~front_q : front_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) front_q <= 1'b0;
        else       front_q <= front_d;
    end

    always_ff @(posedge clk) begin
        if (cap_en) mem_q[~front_q][cap_addr] <= wave_rd_data;
    end

    assign rd_sample = mem_q[front_q][col_addr];
`else
    logic [7:0] mem_q [WAVE_LEN];

    always_ff @(posedge clk) begin
        if (cap_en) mem_q[cap_addr] <= wave_rd_data;
    end

    assign rd_sample = mem_q[col_addr];
`endif

    assign ram_rd_clk   = clk;
    assign ram_rd_en    = ram_rd_en_q;
    assign wave_rd_addr = rd_addr_q;
    assign ram_rd_over  = over_q;
    assign busy         = busy_q;
    assign buf_valid    = valid_q;
    assign col_data     = col_q;
    assign wave_max     = max_q;
    assign wave_min     = min_q;

endmodule
